// File: rtl/chaser_ctrl_pkg.sv
// rtl/chaser_ctrl_pkg.sv - shared types and constants for the LED chaser control front end
package chaser_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PCHK = 2'd1,
    HELD = 2'd2,
    RCHK = 2'd3
  } db_state_t;

  localparam int SPEED_W      = 2;
  localparam int SPEED_LEVELS = 4;

  function automatic logic [SPEED_W-1:0] next_speed(input logic [SPEED_W-1:0] s);
    return (s == SPEED_W'(SPEED_LEVELS - 1)) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus press/release debounce FSM for one button
module btn_debounce
  import chaser_ctrl_pkg::*;
#(
  parameter int DEB_CNT = 500000
) (
  input  logic clk,
  input  logic rs,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic      sync1, sync2;
  db_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rs) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // cnt counts cycles of stable level inside PCHK/RCHK; any glitch restarts the check
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press    = 1'b0;
    case (state)
      IDLE: begin
        if (sync2) begin
          cnt_nx   = '0;
          state_nx = PCHK;
        end
      end
      PCHK: begin
        if (!sync2) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          press    = 1'b1;
          state_nx = HELD;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!sync2) begin
          cnt_nx   = '0;
          state_nx = RCHK;
        end
      end
      RCHK: begin
        if (sync2) begin
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/chaser_ctrl_front.sv
// rtl/chaser_ctrl_front.sv - pause/speed control and step prescaler driving the LED chaser
// Optional single-step button enabled by defining STEP_BTN_EN.
module chaser_ctrl_front
  import chaser_ctrl_pkg::*;
#(
  parameter int DEB_CNT = 500000,
  parameter int DIV0    = 12500000
) (
  input  logic               clk,
  input  logic               rs,
  input  logic               btn_pause,
  input  logic               btn_speed,
`ifdef STEP_BTN_EN
  input  logic               btn_step,
`endif
  output logic               chaser_pause,
  output logic               step_en,
  output logic               paused,
  output logic [SPEED_W-1:0] speed
);

  localparam int PW = $clog2(DIV0);

  logic          pause_press, speed_press;
  logic [PW-1:0] cnt, lim_m1;
  logic          tick, step_fire;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_pause (
    .clk(clk), .rs(rs), .raw(btn_pause), .press(pause_press)
  );

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_speed (
    .clk(clk), .rs(rs), .raw(btn_speed), .press(speed_press)
  );

  assign lim_m1 = PW'((DIV0 >> speed) - 1);

  // a speed change restarts the period, so a coincident tick is dropped
  assign tick = ~paused & (cnt == lim_m1) & ~speed_press;

`ifdef STEP_BTN_EN
  logic step_press;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_step (
    .clk(clk), .rs(rs), .raw(btn_step), .press(step_press)
  );

  assign step_fire = tick | (step_press & paused);
`else
  assign step_fire = tick;
`endif

  always_ff @(posedge clk) begin
    if (rs) begin
      paused       <= 1'b0;
      speed        <= '0;
      cnt          <= '0;
      step_en      <= 1'b0;
      chaser_pause <= 1'b1;
    end else begin
      paused <= paused ^ pause_press;
      if (speed_press) begin
        speed <= next_speed(speed);
      end
      if (speed_press) begin
        cnt <= '0;
      end else if (!paused) begin
        cnt <= (cnt == lim_m1) ? '0 : cnt + 1'b1;
      end
      step_en      <= step_fire;
      chaser_pause <= ~step_fire;
    end
  end

endmodule
